// File: rtl/sr_exc_pkg.sv
// sr_exc_pkg
//   Shared definitions for the SR excitation driver.
//   - sr_state_e : FSM state encoding (IDLE, DRIVE, SETTLE, CHECK)
//   - sr_exc     : excitation function, maps (target d, current q) to {s, r}.
//                  It never returns s=r=1.
package sr_exc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } sr_state_e;

  // (d,q) = (1,0) -> set, (0,1) -> reset, d == q -> hold.
  function automatic logic [1:0] sr_exc(input logic d, input logic q);
    return {d & ~q, ~d & q};
  endfunction

endpackage

// File: rtl/sr_exc_fifo.sv
// sr_exc_fifo
//   DEPTH x 1-bit synchronous FIFO that buffers target bits for the driver.
//   The head entry is presented combinationally on dout_o. This lets the
//   driver decide its excitation in the same cycle that it pops.
//   A push while full is ignored, and so is a pop while empty. A simultaneous
//   push and pop leaves the count unchanged. The pointers wrap modulo DEPTH,
//   so DEPTH must be a power of 2.
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (empties the FIFO)
//   push_i   in   write din_i when not full
//   din_i    in   data bit to write
//   pop_i    in   remove the head entry when not empty
//   dout_o   out  head entry (valid while empty_o=0)
//   full_o   out  DEPTH entries stored
//   empty_o  out  no entries stored
module sr_exc_fifo
  import sr_exc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // The storage is not reset. An entry is only read after it has been written.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (push_ok && (wr_ptr_q == AW'(gi))) begin
        mem_q[gi] <= din_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sr_excitation_driver.sv
// sr_excitation_driver
//   Turns a stream of target next-state bits into legal one-cycle S/R
//   excitation pulses for an external SR flip-flop. Targets are buffered in
//   a DEPTH-entry FIFO. Each target is processed in this order:
//   IDLE (pop) -> DRIVE (one pulse) -> SETTLE -> [CHECK] -> IDLE.
//   s and r are registers and are never high together.
// Configuration macro
//   SR_FB_CHECK_EN : when defined, adds the CHECK state. In CHECK, q_fb is
//                    compared with the target, mismatch pulses and err_cnt
//                    counts (saturating). When undefined, mismatch and
//                    err_cnt are tied to 0.
// Parameters
//   DEPTH          target FIFO entries (power of 2, >= 2)
//   SETTLE_CYCLES  quiet cycles after each pulse (>= 1)
//   CNT_W          width of err_cnt
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   target bit valid
//   in_d      in   target next-state bit
//   in_ready  out  FIFO not full; a push happens on in_valid & in_ready
//   q_fb      in   current Q of the driven SR flop
//   s, r      out  registered set/reset excitation
//   busy      out  FSM not in IDLE
//   done      out  one-cycle pulse when a target has been fully processed
//   mismatch  out  one-cycle pulse when q_fb != target at the check
//   err_cnt   out  saturating mismatch count
module sr_excitation_driver
  import sr_exc_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_d,
  output logic             in_ready,
  input  logic             q_fb,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  // The counter is at least 2 bits wide, so the value 2 always fits.
  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [SW-1:0] SETTLE_TWO  = SW'(2);

  sr_state_e     state_q;
  logic [SW-1:0] settle_q;
  logic          s_q;
  logic          r_q;
  logic          done_q;
  logic          fifo_pop;
  logic          fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

  sr_exc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .din_i   (in_d),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready = ~fifo_full;
  assign fifo_pop = (state_q == ST_IDLE) & ~fifo_empty;
  assign busy     = (state_q != ST_IDLE);
  assign s        = s_q;
  assign r        = r_q;
  assign done     = done_q;

`ifdef SR_FB_CHECK_EN
  logic             tgt_q;
  logic             mismatch_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  assign err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_cnt_q;
`else
  assign mismatch  = 1'b0;
  assign err_cnt   = '0;
`endif

  // done is a register. So it is loaded one cycle early, and goes high
  // during the final SETTLE cycle (or during CHECK when the checker is
  // present). With the checker, q_fb is sampled at the end of the final
  // SETTLE cycle. This lets mismatch, err_cnt and done register together
  // and appear in the CHECK cycle. q_fb has already settled at that point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      done_q     <= 1'b0;
`ifdef SR_FB_CHECK_EN
      tgt_q      <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
`endif
    end else begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      done_q     <= 1'b0;
`ifdef SR_FB_CHECK_EN
      mismatch_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            {s_q, r_q} <= sr_exc(fifo_dout, q_fb);
`ifdef SR_FB_CHECK_EN
            tgt_q      <= fifo_dout;
`endif
            state_q    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          state_q  <= ST_SETTLE;
          settle_q <= SETTLE_INIT;
`ifndef SR_FB_CHECK_EN
          done_q   <= (SETTLE_INIT == SETTLE_ONE);
`endif
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_ONE) begin
`ifdef SR_FB_CHECK_EN
            state_q <= ST_CHECK;
            done_q  <= 1'b1;
            if (q_fb != tgt_q) begin
              mismatch_q <= 1'b1;
              err_cnt_q  <= err_cnt_d;
            end
`else
            state_q <= ST_IDLE;
`endif
          end else begin
            settle_q <= settle_q - 1'b1;
`ifndef SR_FB_CHECK_EN
            done_q   <= (settle_q == SETTLE_TWO);
`endif
          end
        end
        default: begin
          // CHECK, or an unreachable code. Both return to IDLE.
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_excitation_driver.sv
// tb_sr_excitation_driver
//   Bench for sr_excitation_driver. It contains an external SR flop model that
//   closes the q_fb loop. A timeline model works out, for every cycle, what
//   s/r/busy/done/mismatch/err_cnt/in_ready must be, from the job start times
//   of the queued targets. Directed scenarios add literal checks that pin the
//   timeline model, and a randomized phase follows.
//   Optional macro: SR_FB_CHECK_EN (the checker in the DUT and in the model).
module tb_sr_excitation_driver;

  localparam int DEPTH   = 4;
  localparam int SETTLE  = 1;
  localparam int CNT_W   = 8;
`ifdef SR_FB_CHECK_EN
  localparam int CHK     = 1;
`else
  localparam int CHK     = 0;
`endif
  localparam int ERR_MAX = (1 << CNT_W) - 1;
  localparam int HIST    = 8192;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_d     = 1'b0;
  logic             q_fb     = 1'b0;
  logic             in_ready;
  logic             s;
  logic             r;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;

  sr_excitation_driver #(
    .DEPTH         (DEPTH),
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_d     (in_d),
    .in_ready (in_ready),
    .q_fb     (q_fb),
    .s        (s),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // environment: external SR flop, optionally overridden by a stuck-at-0 q_fb
  bit q_flop = 1'b0;
  bit stuck  = 1'b0;
  bit s_prev = 1'b0;
  bit r_prev = 1'b0;
  bit rdy_seen = 1'b0;
  int n_s = 0, n_r = 0, n_done = 0, n_mis = 0;
  bit s_h [HIST];
  bit r_h [HIST];
  bit done_h [HIST];

  // timeline model: the target queue and the job that is currently running
  bit mq[$];
  int free_at  = 0;
  int job_pop  = -1;
  int job_sr   = -1;
  int job_done = -1;
  int n_jobs   = 0;
  int err_m    = 0;
  bit job_s    = 1'b0;
  bit job_r    = 1'b0;
  bit job_tgt  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Called at the negedge of every cycle. It compares the DUT with the
  // model, then advances the model by this cycle's pop and push.
  task automatic observe();
    int e_s, e_r, e_done, e_mis, e_busy, e_rdy;
    s_prev   = s;
    r_prev   = r;
    rdy_seen = in_ready;
    if (cyc < HIST) begin
      s_h[cyc]    = s;
      r_h[cyc]    = r;
      done_h[cyc] = done;
    end
    if (s)        n_s++;
    if (r)        n_r++;
    if (done)     n_done++;
    if (mismatch) n_mis++;
    check("s_and_r", int'(s & r), 0);
    if (rst) begin
      mq.delete();
      job_pop = -1; job_sr = -1; job_done = -1; err_m = 0; free_at = 0;
      check("rst_s", int'(s), 0);
      check("rst_r", int'(r), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_mismatch", int'(mismatch), 0);
      check("rst_err_cnt", int'(err_cnt), 0);
      check("rst_in_ready", int'(in_ready), 1);
      return;
    end
    e_s    = (cyc == job_sr) ? int'(job_s) : 0;
    e_r    = (cyc == job_sr) ? int'(job_r) : 0;
    e_done = (cyc == job_done) ? 1 : 0;
    e_mis  = 0;
    if (CHK == 1 && e_done == 1 && q_fb != job_tgt) begin
      e_mis = 1;
      if (err_m < ERR_MAX) err_m++;
    end
    e_busy = (job_pop >= 0 && cyc > job_pop && cyc <= job_done) ? 1 : 0;
    e_rdy  = (mq.size() < DEPTH) ? 1 : 0;
    check("s", int'(s), e_s);
    check("r", int'(r), e_r);
    check("done", int'(done), e_done);
    check("mismatch", int'(mismatch), e_mis);
    check("err_cnt", int'(err_cnt), err_m);
    check("busy", int'(busy), e_busy);
    check("in_ready", int'(in_ready), e_rdy);
    if (cyc >= free_at && mq.size() > 0) begin
      job_tgt  = mq.pop_front();
      job_pop  = cyc;
      job_sr   = cyc + 1;
      job_s    = job_tgt & ~q_fb;
      job_r    = ~job_tgt & q_fb;
      job_done = cyc + 1 + SETTLE + CHK;
      free_at  = job_done + 1;
      n_jobs++;
    end
    if (in_valid && e_rdy == 1) mq.push_back(in_d);
  endtask

  task automatic step(input bit v, input bit d, input bit rs);
    @(posedge clk);
    #1;
    cyc++;
    if (s_prev)      q_flop = 1'b1;
    else if (r_prev) q_flop = 1'b0;
    q_fb     = stuck ? 1'b0 : q_flop;
    rst      = rs;
    in_valid = v;
    in_d     = d;
    @(negedge clk);
    observe();
  endtask

  task automatic push(input bit d);
    bit ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step(1'b1, d, 1'b0);
      if (rdy_seen) begin
        ok = 1'b1;
        break;
      end
    end
    check("push_accept_timeout", int'(ok), 1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (mq.size() == 0 && cyc > job_done && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", int'(ok), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0, r0, d0, m0, acc, j0;
    bit low_seen, fired;
    bit pat [5];

    // 1: reset held for 3 cycles, q_fb=0
    repeat (3) begin
      step(1'b0, 1'b0, 1'b1);
      check("t1_in_ready", int'(in_ready), 1);
      check("t1_sr", int'({s, r}), 0);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // 2: single push d=1 while q=0. Pinned pulse and done timing.
    step(1'b1, 1'b1, 1'b0);
    p0 = cyc;
    repeat (6) step(1'b0, 1'b0, 1'b0);
    check("t2_s_before", int'(s_h[p0 + 1]), 0);
    check("t2_s_pulse", int'(s_h[p0 + 2]), 1);
    check("t2_r_pulse", int'(r_h[p0 + 2]), 0);
    check("t2_s_after", int'(s_h[p0 + 3]), 0);
    check("t2_done_early", int'(done_h[p0 + 1 + SETTLE + CHK]), 0);
    check("t2_done", int'(done_h[p0 + 2 + SETTLE + CHK]), 1);
    drain();

    // 3: flop from q=0, targets 1,1,0,0,1 -> S,hold,R,hold,S
    q_flop = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    s0 = n_s; r0 = n_r; d0 = n_done; m0 = n_mis;
    for (int i = 0; i < 5; i++) push(pat[i]);
    drain();
    check("t3_s_pulses", n_s - s0, 2);
    check("t3_r_pulses", n_r - r0, 1);
    check("t3_done_pulses", n_done - d0, 5);
    check("t3_mismatches", n_mis - m0, 0);

    // 4: FSM busy, burst of 8 back-to-back pushes overflows the FIFO
    q_flop = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    acc = 0;
    low_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'(i % 2), 1'b0);
      if (rdy_seen) acc++;
      else low_seen = 1'b1;
    end
    drain();
    check("t4_ready_low_seen", int'(low_seen), 1);
    check("t4_some_dropped", int'(acc < 8), 1);

    // 5: q_fb stuck at 0, three d=1 targets, then enough to saturate
    stuck = 1'b1;
    m0 = n_mis;
    for (int i = 0; i < 3; i++) push(1'b1);
    drain();
    check("t5_mismatch_pulses", n_mis - m0, 3 * CHK);
    check("t5_err_cnt3", int'(err_cnt), 3 * CHK);
    for (int i = 0; i < ERR_MAX + 5; i++) push(1'b1);
    drain();
    check("t5_err_cnt_sat", int'(err_cnt), CHK * ERR_MAX);
    stuck = 1'b0;

    // 6: reset during the DRIVE cycle of the 2nd target, with 2 queued
    q_flop = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    j0 = n_jobs;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    fired = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (n_jobs == j0 + 2 && cyc + 1 == job_sr) begin
        step(1'b0, 1'b0, 1'b1);
        check("t6_s_drop", int'(s), 0);
        check("t6_r_drop", int'(r), 0);
        fired = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 1'b0);
    end
    check("t6_reset_hit_drive", int'(fired), 1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    s0 = n_s; r0 = n_r; d0 = n_done;
    repeat (12) step(1'b0, 1'b0, 1'b0);
    check("t6_no_s_after", n_s - s0, 0);
    check("t6_no_r_after", n_r - r0, 0);
    check("t6_no_done_after", n_done - d0, 0);
    check("t6_fifo_empty_ready", int'(in_ready), 1);
    check("t6_idle", int'(busy), 0);

    // randomized traffic at several push densities
    for (int ph = 0; ph < 5; ph++) begin
      int p;
      p = (ph == 0) ? 10 : (ph == 1) ? 40 : (ph == 2) ? 80 : (ph == 3) ? 100 : 60;
      for (int i = 0; i < 300; i++) begin
        step(1'($urandom_range(0, 99) < p), 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
